// File: rtl/vram_pkg.sv
// vram_pkg: shared widths, typedefs and fetch FSM states for the tile-line serializer.
package vram_pkg;
  localparam int TILE_ADDR_W = 12;
  localparam int LINE_W = 256;
  localparam int PIXEL_W = 8;
  localparam int PIXELS = LINE_W / PIXEL_W;
  localparam int IDX_W = $clog2(PIXELS);
  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef logic [LINE_W-1:0] tile_line_t;
  typedef logic [TILE_ADDR_W-1:0] tile_addr_t;
  typedef logic [IDX_W-1:0] pix_idx_t;
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} fetch_state_e;
endpackage

// File: rtl/vram_tile_line_serializer_if.sv
// vram_tile_line_serializer_if: request, tile-memory and pixel-stream signals.
// req_flip_h exists only when TILE_SERIALIZER_FLIP_EN is defined.
interface vram_tile_line_serializer_if;
  import vram_pkg::*;
  logic req_valid;
  logic req_ready;
  tile_addr_t req_line_addr;
`ifdef TILE_SERIALIZER_FLIP_EN
  logic req_flip_h;
`endif
  tile_addr_t mem_read_addr;
  tile_line_t mem_read_data;
  logic pix_en;
  logic pix_valid;
  pixel_t pix_data;
  logic pix_last;
  logic underrun;
  modport master(
`ifdef TILE_SERIALIZER_FLIP_EN
    output req_flip_h,
`endif
    output req_valid, req_line_addr, mem_read_data, pix_en,
    input req_ready, mem_read_addr, pix_valid, pix_data, pix_last, underrun);
  modport slave(
`ifdef TILE_SERIALIZER_FLIP_EN
    input req_flip_h,
`endif
    input req_valid, req_line_addr, mem_read_data, pix_en,
    output req_ready, mem_read_addr, pix_valid, pix_data, pix_last, underrun);
endinterface

// File: rtl/vram_line_buffer.sv
// vram_line_buffer: one tile line with its full flag and latched flip bit.
module vram_line_buffer
  import vram_pkg::*;
(
  input logic clk,
  input logic reset,
  input logic i_load,
  input tile_line_t i_data,
  input logic i_flip,
  input logic i_clear,
  output logic o_full,
  output tile_line_t o_data,
  output logic o_flip
);
  logic r_full, r_flip;
  tile_line_t r_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_flip <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
      r_flip <= i_flip;
    end else if (i_clear) r_full <= 1'b0;
  assign o_full = r_full;
  assign o_data = r_data;
  assign o_flip = r_flip;
endmodule

// File: rtl/vram_tile_line_serializer.sv
// vram_tile_line_serializer: fetches tile lines into a ping-pong buffer pair and streams them as pixels.
// Optional horizontal flip enabled by defining TILE_SERIALIZER_FLIP_EN.
module vram_tile_line_serializer
  import vram_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input logic clk,
  input logic reset,
  vram_tile_line_serializer_if.slave bus
);
  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  fetch_state_e r_state, w_next;
  tile_addr_t r_addr;
  logic [CNT_W-1:0] r_cnt;
  logic r_flip, r_rsel;
  pix_idx_t r_idx, w_pix;
  logic w_req_flip, w_ready, w_accept, w_capture, w_wsel, w_valid, w_consume, w_done;
  logic [1:0] w_full, w_bflip, w_load, w_clear;
  tile_line_t w_bdata [2];
`ifdef TILE_SERIALIZER_FLIP_EN
  assign w_req_flip = bus.req_flip_h;
`else
  assign w_req_flip = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE ? (w_accept ? WAIT : IDLE)
           : r_state == WAIT ? (r_cnt == CNT_W'(1) ? CAPTURE : WAIT) : IDLE;
  end
  always_comb begin
    w_ready = r_state == IDLE && !(&w_full) && !reset;
    w_capture = r_state == CAPTURE;
  end
  assign w_accept = bus.req_valid && w_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_addr <= '0;
      r_cnt <= '0;
      r_flip <= 1'b0;
    end else if (w_accept) begin
      r_addr <= bus.req_line_addr;
      r_cnt <= CNT_W'(READ_LATENCY);
      r_flip <= w_req_flip;
    end else if (r_state == WAIT) r_cnt <= r_cnt - CNT_W'(1);
  // Fill the displayed buffer when it is empty so a line from idle is shown first.
  assign w_wsel = w_full[r_rsel] ? ~r_rsel : r_rsel;
  assign w_load = {w_capture & w_wsel, w_capture & ~w_wsel};
  assign w_clear = {w_done & r_rsel, w_done & ~r_rsel};
  for (genvar b = 0; b < 2; b++) begin : g_buf
    vram_line_buffer u_buf (
      .clk(clk),
      .reset(reset),
      .i_load(w_load[b]),
      .i_data(bus.mem_read_data),
      .i_flip(r_flip),
      .i_clear(w_clear[b]),
      .o_full(w_full[b]),
      .o_data(w_bdata[b]),
      .o_flip(w_bflip[b])
    );
  end
  assign w_valid = w_full[r_rsel];
  assign w_consume = bus.pix_en && w_valid;
  assign w_done = w_consume && &r_idx;
  assign w_pix = w_bflip[r_rsel] ? ~r_idx : r_idx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_idx <= '0;
      r_rsel <= 1'b0;
    end else if (w_consume) begin
      r_idx <= r_idx + 1'b1;
      if (w_done) r_rsel <= ~r_rsel;
    end
  assign bus.req_ready = w_ready;
  assign bus.mem_read_addr = r_addr;
  assign bus.pix_valid = w_valid;
  assign bus.pix_data = w_bdata[r_rsel][w_pix*PIXEL_W +: PIXEL_W];
  assign bus.pix_last = w_valid && &r_idx;
  assign bus.underrun = bus.pix_en && !w_valid && !reset;
endmodule

// File: tb/tb_vram_tile_line_serializer.sv
// tb_vram_tile_line_serializer: directed stimulus with a pixel-queue model checked every cycle.
module tb_vram_tile_line_serializer;
  import vram_pkg::*;
`ifdef TILE_SERIALIZER_FLIP_EN
  localparam bit FLIP_ON = 1'b1;
`else
  localparam bit FLIP_ON = 1'b0;
`endif
  typedef struct {logic [7:0] px; bit last;} ent_t;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, failures = 0, cyc_n = 0, first_cyc = 0;
  bit cur_flip = 1'b0;
  ent_t q[$];
  pixel_t seen [64];
  bit seen_last [64];
  vram_tile_line_serializer_if bus ();
  vram_tile_line_serializer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  function automatic logic [7:0] mem_byte(input logic [11:0] a, input int i);
    return 8'((int'(a) - 5) * 32 + i);
  endfunction
  function automatic tile_line_t line_of(input logic [11:0] a);
    tile_line_t l;
    for (int i = 0; i < 32; i++) l[i*8 +: 8] = mem_byte(a, i);
    return l;
  endfunction
  always @(posedge clk) bus.mem_read_data <= line_of(bus.mem_read_addr);
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  // Model: every accepted line appends its 32 pixels in display order.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      chk("rst_pix_valid", bus.pix_valid, 0);
      chk("rst_underrun", bus.underrun, 0);
      chk("rst_req_ready", bus.req_ready, 0);
    end else begin
      chk("underrun", bus.underrun, bus.pix_en && !bus.pix_valid);
      if (bus.pix_valid) begin
        if (q.size() == 0) chk("spurious_valid", bus.pix_valid, 0);
        else begin
          chk("pix_data", bus.pix_data, q[0].px);
          chk("pix_last", bus.pix_last, q[0].last);
          if (bus.pix_en) void'(q.pop_front());
        end
      end
      if (bus.req_valid && bus.req_ready)
        for (int i = 0; i < 32; i++)
          q.push_back('{mem_byte(bus.req_line_addr, (FLIP_ON && cur_flip) ? 31 - i : i), i == 31});
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [11:0] a, input bit f);
    int n = 0;
    cur_flip = f;
    bus.req_valid = 1'b1;
    bus.req_line_addr = a;
`ifdef TILE_SERIALIZER_FLIP_EN
    bus.req_flip_h = f;
`endif
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", bus.req_ready, 1);
    cyc();
    bus.req_valid = 1'b0;
  endtask
  task automatic watch(input int n);
    int w = 0;
    @(negedge clk);
    while (!bus.pix_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    first_cyc = cyc_n;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      chk("watch_valid", bus.pix_valid, 1);
      seen[i] = bus.pix_data;
      seen_last[i] = bus.pix_last;
    end
    @(negedge clk);
    chk("watch_end_valid", bus.pix_valid, 0);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask
  initial begin
    int c0, k;
    bit acc;
    bus.req_valid = 1'b0;
    bus.req_line_addr = '0;
    bus.pix_en = 1'b0;
`ifdef TILE_SERIALIZER_FLIP_EN
    bus.req_flip_h = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("init_ready", bus.req_ready, 1);
    chk("init_valid", bus.pix_valid, 0);
    chk("init_addr", bus.mem_read_addr, 0);
    chk("init_last", bus.pix_last, 0);
    // Underrun with nothing fetched.
    cyc();
    bus.pix_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_underrun", bus.underrun, 1);
      chk("t5_valid", bus.pix_valid, 0);
      chk("t5_ready", bus.req_ready, 1);
    end
    // Single line, first pixel three cycles after accept.
    cyc();
    c0 = cyc_n;
    fork
      send(12'h005, 1'b0);
      watch(32);
    join
    chk("t2_latency", first_cyc - c0, 3);
    for (int i = 0; i < 32; i++) chk("t2_pixel", seen[i], i);
    chk("t2_last31", seen_last[31], 1);
    chk("t2_last30", seen_last[30], 0);
    // Back-to-back lines stream without a gap.
    cyc();
    fork
      begin
        send(12'h005, 1'b0);
        send(12'h006, 1'b0);
      end
      watch(64);
    join
    for (int i = 0; i < 64; i++) chk("t3_pixel", seen[i], i);
    chk("t3_last63", seen_last[63], 1);
    // Both buffers full stalls the third request.
    cyc();
    bus.pix_en = 1'b0;
    k = 0;
    bus.req_valid = 1'b1;
    bus.req_line_addr = 12'h010;
    repeat (20) begin
      @(negedge clk);
      acc = bus.req_ready;
      cyc();
      if (acc) begin
        k++;
        bus.req_line_addr = 12'h010 + 12'(k);
      end
    end
    chk("t4_accepts", k, 2);
    @(negedge clk);
    chk("t4_ready_low", bus.req_ready, 0);
    cyc();
    bus.pix_en = 1'b1;
    c0 = cyc_n;
    k = 0;
    @(negedge clk);
    while (!bus.req_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("t4_ready_after_32", cyc_n - c0, 32);
    cyc();
    bus.req_valid = 1'b0;
    drain();
    // Reset while a fetch is pending and one buffer is full.
    cyc();
    bus.pix_en = 1'b0;
    send(12'h020, 1'b0);
    k = 0;
    @(negedge clk);
    while (!bus.pix_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t1_full", bus.pix_valid, 1);
    cyc();
    send(12'h021, 1'b0);
    reset = 1'b1;
    bus.pix_en = 1'b1;
    @(negedge clk);
    chk("t1_rst_valid", bus.pix_valid, 0);
    chk("t1_rst_addr", bus.mem_read_addr, 0);
    chk("t1_rst_underrun", bus.underrun, 0);
    cyc();
    reset = 1'b0;
    bus.pix_en = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("t1_no_capture", bus.pix_valid, 0);
      chk("t1_ready", bus.req_ready, 1);
    end
    // Flip ordering (identity order when the feature is compiled out).
    cyc();
    bus.pix_en = 1'b1;
    fork
      begin
        send(12'h7FF, 1'b1);
        send(12'h7FE, 1'b0);
      end
      watch(64);
    join
    chk("t6_first", seen[0], FLIP_ON ? 8'h5F : 8'h40);
    chk("t6_pix31", seen[31], FLIP_ON ? 8'h40 : 8'h5F);
    chk("t6_pix32", seen[32], 8'h20);
    chk("t6_pix63", seen[63], 8'h3F);
    chk("t6_addr", bus.mem_read_addr, 12'h7FE);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
